// File: rtl/phase_seq_pkg.sv
// Shared constants and types for the multicycle phase sequencer.
// Phase table:  phase | meaning
//               PH_IF | instruction fetch
//               PH_ID | decode / register read
//               PH_EX | execute
//               PH_MEM| memory access (may take wait states)
//               PH_WB | register write-back
package phase_seq_pkg;

    localparam int N_PHASES_DEF = 5;

    localparam int PH_IF  = 0;
    localparam int PH_ID  = 1;
    localparam int PH_EX  = 2;
    localparam int PH_MEM = 3;
    localparam int PH_WB  = 4;

    typedef logic [$clog2(N_PHASES_DEF)-1:0] phase_idx_t;

endpackage

// File: rtl/phase_next_pick.sv
// Combinational next-phase search: lowest index above cur_idx whose skip bit
// is clear, or wrap to phase 0 when none remains.
module phase_next_pick
    import phase_seq_pkg::*;
#(
    parameter int N  = N_PHASES_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] cur_idx,
    input  logic [N-1:0]  skip,
    output logic [IW-1:0] nxt_idx,
    output logic          wrap
);

    // Phase 0 is never a forward target, so its skip bit carries no meaning.
    logic unused_skip0;
    assign unused_skip0 = skip[0];

    always_comb begin
        nxt_idx = '0;
        wrap    = 1'b1;
        // Descending scan so the last hit is the lowest qualifying index.
        for (int j = N - 1; j >= 1; j--) begin
            if ((IW'(j) > cur_idx) && !skip[j]) begin
                nxt_idx = IW'(j);
                wrap    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// N-phase one-hot sequencer with ready handshakes, stall, flush and retire count.
// Optional per-instruction phase skipping is enabled by defining PHASE_SKIP_EN.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int N_PHASES = N_PHASES_DEF,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [N_PHASES-1:0]         phase_ready,
    input  logic [N_PHASES-1:0]         skip_mask,
    output logic [N_PHASES-1:0]         phase_oh,
    output logic [$clog2(N_PHASES)-1:0] phase_idx,
    output logic                        instr_done,
    output logic [CNT_W-1:0]            retire_cnt
);

    localparam int IW = $clog2(N_PHASES);

    logic [IW-1:0]       idx_q, idx_d;
    logic [N_PHASES-1:0] oh_q, oh_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                at_first;
    logic                adv;
    logic [N_PHASES-1:0] skip_vec;
    logic [IW-1:0]       pick_idx;
    logic                pick_wrap;

    assign at_first = (idx_q == IW'(PH_IF));
    assign adv      = !stall && phase_ready[idx_q];

`ifdef PHASE_SKIP_EN
    logic [N_PHASES-1:0] skip_lat, skip_lat_d;
    logic [N_PHASES-1:0] skip_in;

    // Leaving phase 0 uses the live mask; later phases use the copy latched then.
    assign skip_in  = skip_mask & ~N_PHASES'(1);
    assign skip_vec = at_first ? skip_in : skip_lat;
`else
    logic unused_skip_mask;
    assign unused_skip_mask = ^skip_mask;
    assign skip_vec         = '0;
`endif

    phase_next_pick #(
        .N  (N_PHASES),
        .IW (IW)
    ) u_pick (
        .cur_idx (idx_q),
        .skip    (skip_vec),
        .nxt_idx (pick_idx),
        .wrap    (pick_wrap)
    );

    always_comb begin
        idx_d  = idx_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
`ifdef PHASE_SKIP_EN
        skip_lat_d = skip_lat;
`endif
        if (flush) begin
            idx_d = IW'(PH_IF);
`ifdef PHASE_SKIP_EN
            skip_lat_d = '0;
`endif
        end else if (adv) begin
            idx_d  = pick_idx;
            done_d = pick_wrap;
            if (pick_wrap) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef PHASE_SKIP_EN
            if (at_first) begin
                skip_lat_d = skip_in;
            end
`endif
        end
        oh_d = N_PHASES'(1) << idx_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            oh_q   <= N_PHASES'(1);
            done_q <= 1'b0;
            cnt_q  <= '0;
`ifdef PHASE_SKIP_EN
            skip_lat <= '0;
`endif
        end else begin
            idx_q  <= idx_d;
            oh_q   <= oh_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
`ifdef PHASE_SKIP_EN
            skip_lat <= skip_lat_d;
`endif
        end
    end

    assign phase_oh   = oh_q;
    assign phase_idx  = idx_q;
    assign instr_done = done_q;
    assign retire_cnt = cnt_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot(phase_oh))
                else $error("phase_oh not one-hot: %b", phase_oh);
            assert (phase_oh == (N_PHASES'(1) << phase_idx))
                else $error("phase_oh %b inconsistent with phase_idx %0d", phase_oh, phase_idx);
        end
    end
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized self-checking bench for phase_sequencer (5-phase/32-bit and 3-phase/2-bit builds).
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] rdy_a = '1;
    logic [4:0] sk_a  = '0;
    logic [2:0] rdy_b = '1;
    logic [2:0] sk_b  = '0;

    logic [4:0]  oh_a;
    logic [2:0]  idx_a;
    logic        done_a;
    logic [31:0] cnt_a;
    logic [2:0]  oh_b;
    logic [1:0]  idx_b;
    logic        done_b;
    logic [1:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    phase_sequencer #(.N_PHASES(5), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .phase_ready(rdy_a), .skip_mask(sk_a),
        .phase_oh(oh_a), .phase_idx(idx_a), .instr_done(done_a), .retire_cnt(cnt_a)
    );

    phase_sequencer #(.N_PHASES(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .phase_ready(rdy_b), .skip_mask(sk_b),
        .phase_oh(oh_b), .phase_idx(idx_b), .instr_done(done_b), .retire_cnt(cnt_b)
    );

    // Reference state per instance: current phase, done flag, count, latched skips.
    int      m_idx [2];
    bit      m_done[2];
    longint  m_cnt [2];
    bit [15:0] m_skip[2];

    function automatic void step(input int k, input int n, input int cw,
                                 input bit [15:0] rdy, input bit [15:0] skin);
        bit [15:0] sk;
        int nxt;
        if (reset) begin
            m_idx[k] = 0; m_done[k] = 0; m_cnt[k] = 0; m_skip[k] = '0;
        end else if (flush) begin
            m_idx[k] = 0; m_done[k] = 0; m_skip[k] = '0;
        end else if (!stall && rdy[m_idx[k]]) begin
`ifdef PHASE_SKIP_EN
            if (m_idx[k] == 0) begin
                m_skip[k] = skin & ~16'd1;
            end
            sk = m_skip[k];
`else
            sk = '0;
`endif
            nxt = -1;
            for (int j = m_idx[k] + 1; j < n; j++) begin
                if (!sk[j]) begin
                    nxt = j;
                    break;
                end
            end
            if (nxt < 0) begin
                m_idx[k]  = 0;
                m_done[k] = 1;
                m_cnt[k]  = (m_cnt[k] + 1) % (longint'(1) << cw);
            end else begin
                m_idx[k]  = nxt;
                m_done[k] = 0;
            end
        end else begin
            m_done[k] = 0;
        end
    endfunction

    always @(posedge clk) begin
        step(0, 5, 32, 16'(rdy_a), 16'(sk_a));
        step(1, 3, 2,  16'(rdy_b), 16'(sk_b));
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model a idx",  idx_a,  m_idx[0]);
            chk("model a oh",   oh_a,   longint'(1) << m_idx[0]);
            chk("model a done", done_a, m_done[0]);
            chk("model a cnt",  cnt_a,  m_cnt[0]);
            chk("model b idx",  idx_b,  m_idx[1]);
            chk("model b oh",   oh_b,   longint'(1) << m_idx[1]);
            chk("model b done", done_b, m_done[1]);
            chk("model b cnt",  cnt_b,  m_cnt[1]);
        end
    end

    // Inputs change on the falling edge; outputs are read at the next falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic run_seq(input string name, input int exp_q[$]);
        foreach (exp_q[i]) begin
            cyc();
            chk({name, " idx"},  idx_a,  exp_q[i]);
            chk({name, " done"}, done_a, (exp_q[i] == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int q[$];
        int exp_cnt;

        @(negedge clk);
        check_en = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        chk("reset idx",  idx_a,  0);
        chk("reset oh",   oh_a,   1);
        chk("reset done", done_a, 0);
        chk("reset cnt",  cnt_a,  0);

        // Plain rotation.
        q = '{1, 2, 3, 4, 0};
        run_seq("rotate", q);
        chk("rotate cnt", cnt_a, 1);

        // Two wait states in phase 3.
        q = '{1, 2, 3};
        run_seq("wait pre", q);
        rdy_a = 5'b10111;
        q = '{3, 3};
        run_seq("wait hold", q);
        rdy_a = '1;
        q = '{4, 0};
        run_seq("wait post", q);
        chk("wait cnt", cnt_a, 2);

        // Skip phase 3, then single-cycle instructions.
        sk_a = 5'b01000;
        cyc();
        chk("skip3 first idx", idx_a, 1);
        sk_a = '0;
`ifdef PHASE_SKIP_EN
        q = '{2, 4, 0};
`else
        q = '{2, 3, 4, 0};
`endif
        run_seq("skip3", q);
        chk("skip3 cnt", cnt_a, 3);
        sk_a = 5'b11110;
`ifdef PHASE_SKIP_EN
        q = '{0, 0};
        exp_cnt = 5;
`else
        q = '{1, 2};
        exp_cnt = 4;
`endif
        run_seq("skipall", q);
        sk_a = '0;
`ifndef PHASE_SKIP_EN
        q = '{3, 4, 0};
        run_seq("skipall tail", q);
`endif
        chk("skipall cnt", cnt_a, exp_cnt);

        // Flush together with stall in phase 2.
        q = '{1, 2};
        run_seq("flush pre", q);
        stall = 1'b1;
        flush = 1'b1;
        cyc();
        chk("flush idx",  idx_a,  0);
        chk("flush done", done_a, 0);
        chk("flush cnt",  cnt_a,  exp_cnt);
        stall = 1'b0;
        flush = 1'b0;
        q = '{1, 2, 3, 4, 0};
        run_seq("after flush", q);
        chk("after flush cnt", cnt_a, exp_cnt + 1);

        // Reset in phase 3.
        q = '{1, 2, 3};
        run_seq("rst pre", q);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst idx",  idx_a,  0);
        chk("midrst done", done_a, 0);
        chk("midrst cnt",  cnt_a,  0);
        chk("midrst b cnt", cnt_b, 0);

        // 3-phase build: period 3, 2-bit counter wraps.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("b period idx1", idx_b, 1);
            cyc();
            chk("b period idx2", idx_b, 2);
            cyc();
            chk("b wrap idx",  idx_b,  0);
            chk("b wrap done", done_b, 1);
            chk("b wrap cnt",  cnt_b,  (i + 1) % 4);
        end
        chk("a after 15 idx", idx_a, 0);
        chk("a after 15 cnt", cnt_a, 3);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            flush = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 5; b++) rdy_a[b] = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 3; b++) rdy_b[b] = ($urandom_range(0, 3) != 0);
            sk_a = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom);
            sk_b = 3'($urandom);
            cyc();
        end

        reset = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        cyc();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
